sonic_pcs_rx_st_packet_arbiter: RTL
===================================

Name: sonic_pcs_rx_st_packet_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one 72-bit Avalon-ST RX stream (64b data + 8b sideband) between NUM_IN requesters.
- Sits upstream of the 10G MAC RX timing adapter.
- Once granted, a requester holds the output until its endofpacket beat is accepted, so packets are never interleaved.
- Honours downstream ready (backpressure) and exposes grant and busy status.

Parameters:
- DATA_W, 72, payload width per beat (data plus sideband, opaque to arbiter).
- NUM_IN, 2, number of requesters; legal range 2..4.
- GRANT_W, 2, width of grant index; must be at least clog2(NUM_IN).
- TIMEOUT_CYCLES, 1024, stall limit for the optional watchdog; 16-bit counter.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_data  in  NUM_IN*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_IN  per-requester valid.
- in_startofpacket  in  NUM_IN  per-requester SOP.
- in_endofpacket  in  NUM_IN  per-requester EOP.
- in_ready  out  NUM_IN  per-requester ready.
- out_data  out  DATA_W  granted payload.
- out_valid  out  1  output valid.
- out_startofpacket  out  1  output SOP.
- out_endofpacket  out  1  output EOP.
- out_ready  in  1  downstream ready.
- grant_id  out  GRANT_W  index of the current or last granted requester.
- busy  out  1  high while a packet is in flight.
- protocol_err  out  1  one-cycle pulse on a discarded stray beat.
- timeout_err  out  1  one-cycle watchdog pulse; tied 0 when the watchdog is compiled out.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, grant_id=NUM_IN-1 so requester 0 wins first, busy=0.
  - All in_ready=0, protocol_err=0, timeout_err=0, stall counter=0.
  - Reset mid-packet abandons the packet; no EOP is synthesised.
- Request definition: req[i] = in_valid[i] & in_startofpacket[i].
- IDLE:
  - out_valid=0; in_ready=0 except for stray-beat discard (below).
  - If any req, pick the first requester after grant_id in cyclic order.
  - Next cycle: grant_id=winner, state=BUSY, busy=1.
  - Arbitration costs exactly one bubble cycle between packets.
- Stray beats in IDLE:
  - in_valid[i]=1 with in_startofpacket[i]=0: assert in_ready[i] that cycle to discard the beat, and pulse protocol_err next cycle.
  - Lowest index wins if several stray beats coincide; one discard per cycle.
  - Stray discard is suppressed in any cycle where a req exists.
- BUSY (g=grant_id):
  - out_data/out_valid/out_startofpacket/out_endofpacket = requester g's signals, combinationally.
  - in_ready[g] = out_ready; all other in_ready = 0.
  - Zero-cycle latency through the block.
- Accept rule: a beat is accepted when in_valid[g] & out_ready.
- Release: an accepted beat with in_endofpacket[g]=1 moves state to IDLE next cycle; busy=0; grant_id keeps g for round-robin.
- Single-beat packet (SOP and EOP on the same beat): granted, transferred, released; total 2 cycles from request to IDLE.
- Gaps: in_valid[g]=0 mid-packet holds the grant indefinitely (watchdog aside); out_valid follows in_valid[g].
- Backpressure: while out_ready=0, out_data and out_valid follow the source unchanged; the source must hold per Avalon-ST rules.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_IN-1,0; no requester waits more than NUM_IN-1 packets.

Optional Feature:
- Macro: SONIC_RX_ARB_WATCHDOG_EN.
- Defined:
  - In BUSY, a 16-bit stall counter increments each cycle with no accepted beat and clears on an accepted beat.
  - When the count reaches TIMEOUT_CYCLES-1, force state=IDLE next cycle and pulse timeout_err for one cycle.
  - Counter clears on entry to IDLE.
  - Remaining beats of the abandoned packet arrive without SOP and are discarded as stray (protocol_err per beat).
- Undefined: no counter; timeout_err constant 0; grant is held indefinitely.

Test Plan:
- Reset then req on input 1 only, 4-beat packet, out_ready=1 → grant_id=1 one cycle after request; out beats 1..4 with SOP on beat 1 and EOP on beat 4; busy falls the cycle after EOP.
- Inputs 0 and 1 request simultaneously and continuously, 2-beat packets → output packet order 0,1,0,1; exactly one idle bubble between packets; never interleaved.
- Granted packet of 3 beats with out_ready toggling 1,0,0,1,1 → in_ready[g] mirrors out_ready; 3 beats accepted on the ready-high cycles only; data stable while stalled.
- In IDLE, input 0 presents valid=1, SOP=0, data 0xAA → in_ready[0]=1 for one cycle; protocol_err pulses next cycle; no output beat.
- Single-beat packet (SOP=EOP=1) on input 1, followed immediately by a request on input 0 → input 1 beat out; input 0 granted in the next arbitration cycle.
- Watchdog build, TIMEOUT_CYCLES=8: granted source drops valid after SOP → timeout_err pulses after 8 stalled cycles; busy=0 next cycle. Non-watchdog build with the same stimulus → busy stays 1.

Source files
------------

// File: rtl/sonic_pcs_rx_st_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST RX stream between NUM_IN sources.
// Define SONIC_RX_ARB_WATCHDOG_EN to build in the stall watchdog that drives timeout_err.
module sonic_pcs_rx_st_packet_arbiter #(
  parameter int DATA_W         = 72,
  parameter int NUM_IN         = 2,
  parameter int GRANT_W        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  input  logic                     out_ready,
  output logic [GRANT_W-1:0]       grant_id,
  output logic                     busy,
  output logic                     protocol_err,
  output logic                     timeout_err
);
  localparam int SLOTS = 1 << GRANT_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg;
  logic [GRANT_W-1:0] grant_reg;
  logic               perr_reg;

  logic [DATA_W-1:0]  data_slot [SLOTS];
  logic [SLOTS-1:0]   valid_slot;
  logic [SLOTS-1:0]   sop_slot;
  logic [SLOTS-1:0]   eop_slot;
  logic [SLOTS-1:0]   req_slot;
  logic [SLOTS-1:0]   ready_slot;
  logic [NUM_IN-1:0]  stray_vec;
  logic [NUM_IN-1:0]  stray_pick;
  logic [GRANT_W-1:0] win_idx;
  logic [GRANT_W-1:0] cand;
  logic               any_req;
  logic               in_busy;
  logic               accept;
  logic               wd_fire;

  if (NUM_IN < 2 || NUM_IN > 4 || SLOTS < NUM_IN || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
    $error("sonic_pcs_rx_st_packet_arbiter: unsupported parameter set");
  end

  // Pad the per-source views to a power of two so grant_reg can index them directly.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_IN) begin : g_used
        assign data_slot[gi]  = in_data[gi*DATA_W +: DATA_W];
        assign valid_slot[gi] = in_valid[gi];
        assign sop_slot[gi]   = in_startofpacket[gi];
        assign eop_slot[gi]   = in_endofpacket[gi];
      end else begin : g_pad
        assign data_slot[gi]  = '0;
        assign valid_slot[gi] = 1'b0;
        assign sop_slot[gi]   = 1'b0;
        assign eop_slot[gi]   = 1'b0;
      end
    end
  endgenerate

  assign req_slot   = valid_slot & sop_slot;
  assign any_req    = |req_slot;
  assign stray_vec  = in_valid & ~in_startofpacket;
  assign stray_pick = stray_vec & (~stray_vec + NUM_IN'(1));
  assign in_busy    = (state_reg == BUSY);
  assign accept     = in_busy & valid_slot[grant_reg] & out_ready;

  // Walk the ring backwards so the nearest requester after the last grant wins.
  always_comb begin
    win_idx = grant_reg;
    cand    = grant_reg;
    for (int k = NUM_IN; k >= 1; k--) begin
      cand = GRANT_W'((int'(grant_reg) + k) % NUM_IN);
      if (req_slot[cand]) win_idx = cand;
    end
  end

  always_comb begin
    ready_slot = '0;
    if (in_busy) ready_slot[grant_reg] = out_ready;
    if (!reset_n)
      in_ready = '0;
    else if (in_busy)
      in_ready = ready_slot[NUM_IN-1:0];
    else if (any_req)
      in_ready = '0;
    else
      in_ready = stray_pick;
  end

  assign out_data          = data_slot[grant_reg];
  assign out_valid         = in_busy & valid_slot[grant_reg];
  assign out_startofpacket = in_busy & sop_slot[grant_reg];
  assign out_endofpacket   = in_busy & eop_slot[grant_reg];
  assign grant_id          = grant_reg;
  assign busy              = in_busy;
  assign protocol_err      = perr_reg;

`ifdef SONIC_RX_ARB_WATCHDOG_EN
  logic [15:0] stall_cnt_reg;
  logic        timeout_reg;

  assign wd_fire = in_busy && !accept && (stall_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      timeout_reg <= wd_fire;
      if (!in_busy || accept || wd_fire)
        stall_cnt_reg <= '0;
      else
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign timeout_err = timeout_reg;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      grant_reg <= GRANT_W'(NUM_IN - 1);
      perr_reg  <= 1'b0;
    end else begin
      perr_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (any_req) begin
          state_reg <= BUSY;
          grant_reg <= win_idx;
        end else if (|stray_vec) begin
          perr_reg <= 1'b1;
        end
      end else if ((accept && eop_slot[grant_reg]) || wd_fire) begin
        state_reg <= IDLE;
      end
    end
  end
endmodule
